// File: rtl/wr_resp_direction_buffer.sv
// Per-direction write-response return buffer: one independent FIFO per direction,
// valid/ready drain to each master, almost-full backpressure and sticky overflow flags.
module wr_resp_direction_buffer #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 1,
    parameter int TXNID_W  = 8,
    parameter int SB_W     = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [WIDTH-1:0]                  v_in_vld,
    input  logic [WIDTH*(TXNID_W+SB_W)-1:0]   v_in_pld,
    output logic [WIDTH-1:0]                  v_out_vld,
    output logic [WIDTH*(TXNID_W+SB_W)-1:0]   v_out_pld,
    input  logic [WIDTH-1:0]                  v_out_rdy,
    output logic [WIDTH-1:0]                  v_afull,
    output logic [WIDTH-1:0]                  v_ovf
);

    // Each payload slot is {sideband, txnid}.
    localparam int PLD_W = TXNID_W + SB_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_TH);

    for (genvar i = 0; i < WIDTH; i++) begin : g_dir
        logic [PLD_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic             ovf;
        logic             empty;
        logic             full;
        logic             pop;
        logic             push;

        assign empty = (count == '0);
        assign full  = (count == FULL_LVL);
        assign pop   = !empty && v_out_rdy[i];
        // A full FIFO still accepts a push when the head leaves on the same edge.
        assign push  = v_in_vld[i] && (!full || pop);

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;

                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;

                if (v_in_vld[i] && full && !pop) ovf <= 1'b1;
            end
        end

        // NOTE: storage is deliberately not reset; the pointers and count define
        // which entries are live, so clearing the array would only cost reset fan-out.
        always_ff @(posedge clk) begin
            if (rst_n && push) mem[wr_ptr] <= v_in_pld[i*PLD_W +: PLD_W];
        end

        assign v_out_vld[i]                 = !empty;
        assign v_out_pld[i*PLD_W +: PLD_W]  = mem[rd_ptr];
        assign v_afull[i]                   = (count >= AFULL_LVL);
        assign v_ovf[i]                     = ovf;
    end

endmodule

// File: tb/tb_wr_resp_direction_buffer.sv
// Scoreboard bench for wr_resp_direction_buffer: stimulus pushes expected payloads
// into per-direction queues, a negedge monitor pops and compares on every handshake.
module tb_wr_resp_direction_buffer;

    localparam int W  = 4;
    localparam int PW = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    v_in_vld;
    logic [W*PW-1:0] v_in_pld;
    logic [W-1:0]    v_out_vld;
    logic [W*PW-1:0] v_out_pld;
    logic [W-1:0]    v_out_rdy;
    logic [W-1:0]    v_afull;
    logic [W-1:0]    v_ovf;

    logic [PW-1:0] exp_q [W][$];
    int checks = 0;
    int errors = 0;

    wr_resp_direction_buffer #(
        .WIDTH(4), .DEPTH(4), .AFULL_TH(1), .TXNID_W(8), .SB_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .v_in_vld  (v_in_vld),
        .v_in_pld  (v_in_pld),
        .v_out_vld (v_out_vld),
        .v_out_pld (v_out_pld),
        .v_out_rdy (v_out_rdy),
        .v_afull   (v_afull),
        .v_ovf     (v_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int d, input logic [7:0] t);
        return {t[3:0] ^ 4'(d), t};
    endfunction

    function automatic logic [7:0] head_txnid(input int d);
        return v_out_pld[d*PW +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input int d, input logic [7:0] t, input bit accept);
        v_in_vld[d]          = 1'b1;
        v_in_pld[d*PW +: PW] = mk(d, t);
        if (accept) exp_q[d].push_back(mk(d, t));
        tick();
        v_in_vld[d] = 1'b0;
    endtask

    // Monitor: every handshake visible at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < W; d++) begin
                if (v_out_vld[d] && v_out_rdy[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out dir%0d: got %0h expected none",
                                 d, v_out_pld[d*PW +: PW]);
                    end else begin
                        check($sformatf("order_dir%0d", d), 32'(v_out_pld[d*PW +: PW]),
                              32'(exp_q[d].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        v_in_vld  = '0;
        v_in_pld  = '0;
        v_out_rdy = '0;

        // Reset then idle, single push latency
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_vld",   32'(v_out_vld), 32'h0);
        check("reset_afull", 32'(v_afull),   32'h0);
        check("reset_ovf",   32'(v_ovf),     32'h0);
        v_in_vld[1]      = 1'b1;
        v_in_pld[PW+:PW] = mk(1, 8'h05);
        exp_q[1].push_back(mk(1, 8'h05));
        #2;
        check("no_bypass", 32'(v_out_vld), 32'h0);
        tick();
        v_in_vld[1] = 1'b0;
        check("vld_one_cycle", 32'(v_out_vld), 32'b0010);
        check("dir1_txnid",    32'(head_txnid(1)), 32'h05);
        v_out_rdy[1] = 1'b1;
        tick();
        tick();
        v_out_rdy[1] = 1'b0;
        check("dir1_drained", 32'(v_out_vld[1]), 32'h0);

        // Ordering and backpressure on dir0
        drive_push(0, 8'h10, 1'b1);
        drive_push(0, 8'h14, 1'b1);
        drive_push(0, 8'h18, 1'b1);
        check("hold_head_a", 32'(head_txnid(0)), 32'h10);
        tick();
        check("hold_head_b", 32'(head_txnid(0)), 32'h10);
        v_out_rdy[0] = 1'b1;
        tick();
        tick();
        check("dir0_one_left", 32'(v_out_vld[0]), 32'h1);
        tick();
        check("dir0_empty", 32'(v_out_vld[0]), 32'h0);
        v_out_rdy[0] = 1'b0;

        // Almost-full, full and overflow on dir2
        drive_push(2, 8'h20, 1'b1);
        drive_push(2, 8'h21, 1'b1);
        check("afull_cnt2", 32'(v_afull), 32'h0);
        drive_push(2, 8'h22, 1'b1);
        check("afull_cnt3", 32'(v_afull), 32'b0100);
        drive_push(2, 8'h23, 1'b1);
        check("afull_cnt4", 32'(v_afull[2]), 32'h1);
        check("ovf_before", 32'(v_ovf),      32'h0);
        drive_push(2, 8'h24, 1'b0);
        check("ovf_set",       32'(v_ovf),          32'b0100);
        check("full_head_kept", 32'(head_txnid(2)), 32'h20);
        v_out_rdy[2] = 1'b1;
        repeat (4) tick();
        v_out_rdy[2] = 1'b0;
        check("dir2_drained", 32'(v_out_vld[2]), 32'h0);
        check("ovf_sticky",   32'(v_ovf[2]),     32'h1);

        // Full with simultaneous push and pop on dir3
        drive_push(3, 8'h30, 1'b1);
        drive_push(3, 8'h31, 1'b1);
        drive_push(3, 8'h32, 1'b1);
        drive_push(3, 8'h33, 1'b1);
        v_out_rdy[3] = 1'b1;
        drive_push(3, 8'h34, 1'b1);
        v_out_rdy[3] = 1'b0;
        check("pp_no_ovf",   32'(v_ovf[3]),       32'h0);
        check("pp_still_af", 32'(v_afull[3]),     32'h1);
        check("pp_head_b",   32'(head_txnid(3)),  32'h31);
        v_out_rdy[3] = 1'b1;
        repeat (4) tick();
        v_out_rdy[3] = 1'b0;
        check("dir3_drained", 32'(v_out_vld[3]), 32'h0);

        // Pointer wrap streaming on dir0
        v_out_rdy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_push(0, 8'h50 + 8'(i), 1'b1);
            tick();
        end
        v_out_rdy[0] = 1'b0;
        check("wrap_no_ovf", 32'(v_ovf[0]),        32'h0);
        check("wrap_empty",  32'(v_out_vld[0]),    32'h0);
        check("wrap_q_done", 32'(exp_q[0].size()), 32'h0);

        // Reset mid-operation with a coincident push
        for (int k = 0; k < 3; k++) begin
            v_in_vld = '1;
            for (int d = 0; d < W; d++) begin
                v_in_pld[d*PW +: PW] = mk(d, 8'h60 + 8'(d*4 + k));
                exp_q[d].push_back(mk(d, 8'h60 + 8'(d*4 + k)));
            end
            tick();
            v_in_vld = '0;
        end
        check("pre_rst_vld", 32'(v_out_vld), 32'hF);
        check("pre_rst_ovf", 32'(v_ovf),     32'b0100);
        rst_n    = 1'b0;
        v_in_vld = '1;
        for (int d = 0; d < W; d++) v_in_pld[d*PW +: PW] = mk(d, 8'h70 + 8'(d));
        tick();
        rst_n    = 1'b1;
        v_in_vld = '0;
        for (int d = 0; d < W; d++) exp_q[d].delete();
        check("mid_rst_vld",   32'(v_out_vld), 32'h0);
        check("mid_rst_ovf",   32'(v_ovf),     32'h0);
        check("mid_rst_afull", 32'(v_afull),   32'h0);
        drive_push(0, 8'h77, 1'b1);
        check("post_rst_head", 32'(head_txnid(0)), 32'h77);
        v_out_rdy[0] = 1'b1;
        tick();
        v_out_rdy[0] = 1'b0;

        for (int d = 0; d < W; d++)
            check($sformatf("final_q%0d_empty", d), 32'(exp_q[d].size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wr_resp_direction_buffer.md
Name: wr_resp_direction_buffer

Overview:
- Per-direction write-response return buffer.
- Sits directly downstream of the write-response direction decoder. It captures the one-cycle v_wresp_vld/v_wresp_pld pulses for each of the WIDTH directions into an independent FIFO per direction.
- It presents each FIFO to that direction's master through a valid/ready handshake.
- It flags a nearly-full FIFO to the upstream request pipeline and records a sticky error on any lost response.

Parameters:
- WIDTH, 4, number of directions; one FIFO per direction.
- DEPTH, 4, entries per direction FIFO; power of 2, minimum 2.
- AFULL_TH, 1, v_afull[i] asserts when free entries <= AFULL_TH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- v_in_vld  input  WIDTH  per-direction response push; one-cycle pulse from the decoder.
- v_in_pld  input  wr_resp_pld_t x WIDTH  per-direction payload (txnid, sideband).
- v_out_vld  output  WIDTH  per-direction response valid to master.
- v_out_pld  output  wr_resp_pld_t x WIDTH  per-direction head-of-FIFO payload.
- v_out_rdy  input  WIDTH  per-direction master ready.
- v_afull  output  WIDTH  per-direction almost-full, used as upstream backpressure.
- v_ovf  output  WIDTH  per-direction sticky overflow error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising clk edge.
- Reset clears every direction's write pointer, read pointer, count and v_ovf. Storage RAM is not cleared.
- Output values during and after reset: v_out_vld=0, v_afull=0 (because AFULL_TH < DEPTH), v_ovf=0. v_out_pld is don't-care while v_out_vld=0.
- A reset asserted mid-operation discards all queued responses in the same edge. A push on the reset edge is ignored.
- Per direction i, all directions are fully independent (no shared arbitration):
  - Push: v_in_vld[i]=1 writes v_in_pld[i] at wr_ptr, then wr_ptr++ (wraps mod DEPTH).
  - Pop: v_out_vld[i] & v_out_rdy[i] advances rd_ptr (wraps mod DEPTH).
  - count is $clog2(DEPTH+1) bits. It updates +1 on push only, -1 on pop only, and is unchanged on push+pop.
- Output rules:
  - v_out_vld[i] = (count != 0), driven from registered state.
  - v_out_pld[i] = mem[rd_ptr] and stays stable while v_out_vld=1 and v_out_rdy=0.
  - Latency: a push into an empty FIFO gives v_out_vld=1 on the next cycle. There is no same-cycle bypass.
  - Back-to-back pops are allowed; a drained FIFO sustains 1 response/cycle.
- v_afull[i] = (DEPTH - count) <= AFULL_TH, combinational from registered count.
- Full with push and no pop: the push is dropped, storage and pointers are unchanged, and v_ovf[i] sets on the next cycle and holds until reset.
- Full with push and pop in the same cycle: the push is accepted, count stays DEPTH, and v_ovf is not set.
- Empty with pop attempt: impossible, since v_out_vld=0. v_out_rdy is ignored when empty.
- Order is strict FIFO per direction. No reordering across or within directions.

Test Plan:
- Reset then idle: drive rst_n=0 for 2 cycles, then release. Check v_out_vld=0000, v_afull=0000, v_ovf=0000. Push txnid=0x05 on dir1. Check v_out_vld=0010 exactly one cycle later and v_out_pld[1].txnid=0x05.
- Ordering and backpressure: push txnid 0x10,0x14,0x18 on dir0 with v_out_rdy[0]=0. v_out_pld[0] stays 0x10. Raise rdy. Dir0 outputs 0x10,0x14,0x18 on consecutive cycles, then v_out_vld[0]=0.
- Almost-full and full (DEPTH=4, AFULL_TH=1): push 3 entries to dir2, then v_afull[2]=1. Push a 4th, then v_afull stays 1 and count is 4. Push a 5th with rdy=0, then v_ovf[2]=1 next cycle. Drain returns only the first 4 txnids.
- Full with simultaneous push and pop: fill dir3 with A,B,C,D. Push E while rdy=1. Check A is popped, v_ovf[3]=0, and the drain order is B,C,D,E.
- Pointer wrap: stream 10 pushes and pops with 1-cycle spacing on dir0. Check all 10 txnids return in order and v_ovf stays 0.
- Reset mid-operation: with 3 entries queued on all directions and v_ovf[2]=1, assert rst_n=0 for 1 cycle with a coincident push. Next cycle v_out_vld=0000 and v_ovf=0000. A subsequent push returns its own txnid first.
